if_stage: RTL and testbench

Instruction-fetch stage of the toy CPU pipeline. Holds the program counter, issues one-at-a-time requests to instruction memory over a req/ack handshake, and presents fetched instructions to the IF_ID pipeline register. It also absorbs downstream stalls with a one-entry skid buffer, and applies branch redirects from ID, discarding in-flight and buffered fetches.

---
 rtl/if_stage.sv | 143 ++++++++++++++
 tb/tb_if_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, one-outstanding req/ack fetch, one-entry skid
// buffer for downstream stalls, and branch redirect that discards stale fetches.
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branchFlag,
  input  logic [ADDR_W-1:0] branchTarget,
  output logic              memReq,
  output logic [ADDR_W-1:0] memAddr,
  input  logic              memAck,
  input  logic [INST_W-1:0] memData,
  output logic [ADDR_W-1:0] ifPC,
  output logic [INST_W-1:0] ifInst,
  output logic              ifValid,
  output logic [1:0]        dbgState
);

  // Handshakes: memReq rises only in FETCH/DROP, memAddr is stable while memReq=1,
  // and a transfer happens on any rising edge where memReq && memAck.
  // The output register is consumed on any rising edge where ifValid && !stall.

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DROP = 2'd3} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [ADDR_W-1:0] dropAddr, dropAddrNext;
  logic [ADDR_W-1:0] skPC, skPCNext, ifPCNext;
  logic [INST_W-1:0] skInst, skInstNext, ifInstNext;
  logic              skValid, skValidNext, ifValidNext;
  logic              consume;
  logic [ADDR_W-1:0] target;

  assign consume  = ifValid && !stall;
  assign target   = branchTarget & ~ADDR_W'(3);
  assign memReq   = (state == FETCH) || (state == DROP);
  assign memAddr  = (state == DROP) ? dropAddr : pc;
  assign dbgState = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    dropAddrNext = dropAddr;
    ifValidNext  = ifValid;
    ifPCNext     = ifPC;
    ifInstNext   = ifInst;
    skValidNext  = skValid;
    skPCNext     = skPC;
    skInstNext   = skInst;

    // A consumed instruction leaves the output empty unless refilled below.
    if (consume) begin
      ifValidNext = 1'b0;
      ifPCNext    = '0;
      ifInstNext  = '0;
    end

    if (branchFlag) begin
      pcNext      = target;
      ifValidNext = 1'b0;
      ifPCNext    = '0;
      ifInstNext  = '0;
      skValidNext = 1'b0;
      case (state)
        FETCH: begin
          if (memAck) begin
            stateNext = FETCH;
          end else begin
            // Request cannot be withdrawn; remember its address until the ack.
            stateNext    = DROP;
            dropAddrNext = pc;
          end
        end
        DROP:    stateNext = memAck ? FETCH : DROP;
        default: stateNext = FETCH;
      endcase
    end else begin
      case (state)
        IDLE: stateNext = FETCH;
        FETCH: begin
          if (memAck) begin
            pcNext = pc + ADDR_W'(4);
            if (!ifValid || consume) begin
              ifValidNext = 1'b1;
              ifPCNext    = pc;
              ifInstNext  = memData;
            end else begin
              skValidNext = 1'b1;
              skPCNext    = pc;
              skInstNext  = memData;
              stateNext   = HOLD;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            ifValidNext = skValid;
            ifPCNext    = skPC;
            ifInstNext  = skInst;
            skValidNext = 1'b0;
            stateNext   = FETCH;
          end
        end
        DROP: begin
          if (memAck) stateNext = FETCH;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      dropAddr <= RESET_PC;
      ifValid  <= 1'b0;
      ifPC     <= '0;
      ifInst   <= '0;
      skValid  <= 1'b0;
      skPC     <= '0;
      skInst   <= '0;
    end else begin
      pc       <= pcNext;
      dropAddr <= dropAddrNext;
      ifValid  <= ifValidNext;
      ifPC     <= ifPCNext;
      ifInst   <= ifInstNext;
      skValid  <= skValidNext;
      skPC     <= skPCNext;
      skInst   <= skInstNext;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming fetch, stall/skid, redirects (DROP and
// same-cycle ack), PC wrap on a second instance, and async reset mid-DROP.
module tb_if_stage;

  localparam logic [1:0] S_IDLE = 2'd0, S_FETCH = 2'd1, S_HOLD = 2'd2, S_DROP = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, branchFlag;
  logic [31:0] branchTarget;
  logic        memReq, memAck;
  logic [31:0] memAddr, memData;
  logic [31:0] ifPC, ifInst;
  logic        ifValid;
  logic [1:0]  dbgState;

  logic        zeroWait, manAck;

  logic        mem2Req;
  logic [31:0] mem2Addr, if2PC, if2Inst;
  logic        if2Valid;
  logic [1:0]  dbg2State;

  int checks = 0;
  int errors = 0;

  // Memory model: instruction word is the bitwise inverse of its address.
  assign memAck  = zeroWait ? memReq : manAck;
  assign memData = ~memAddr;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branchFlag(branchFlag),
    .branchTarget(branchTarget), .memReq(memReq), .memAddr(memAddr),
    .memAck(memAck), .memData(memData), .ifPC(ifPC), .ifInst(ifInst),
    .ifValid(ifValid), .dbgState(dbgState)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .branchFlag(1'b0),
    .branchTarget(32'h0), .memReq(mem2Req), .memAddr(mem2Addr),
    .memAck(mem2Req), .memData(~mem2Addr), .ifPC(if2PC), .ifInst(if2Inst),
    .ifValid(if2Valid), .dbgState(dbg2State)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, ifValid}, {31'd0, v});
    chk({tag, ".pc"}, ifPC, pc);
    chk({tag, ".inst"}, ifInst, v ? ~pc : 32'h0);
  endtask

  task automatic chk_mem(input string tag, input logic r, input logic [31:0] a);
    chk({tag, ".req"}, {31'd0, memReq}, {31'd0, r});
    chk({tag, ".addr"}, memAddr, a);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branchFlag = 1'b0; branchTarget = '0;
    zeroWait = 1'b1; manAck = 1'b0;
    tick(); tick();
    chk_out("reset", 1'b0, 32'h0);
    chk_mem("reset", 1'b0, 32'h0);
    chk("reset.state", {30'd0, dbgState}, {30'd0, S_IDLE});
    chk("reset2.addr", mem2Addr, 32'hFFFF_FFF8);
    rst = 1'b0;

    // Zero-wait streaming.
    tick();                                   // E1: IDLE -> FETCH
    chk("e1.state", {30'd0, dbgState}, {30'd0, S_FETCH});
    chk_mem("e1", 1'b1, 32'h0);
    chk_out("e1", 1'b0, 32'h0);
    tick();                                   // E2
    chk_out("e2", 1'b1, 32'h0);
    chk_mem("e2", 1'b1, 32'h4);
    chk("wrap.e2", if2PC, 32'hFFFF_FFF8);
    tick();                                   // E3
    chk_out("e3", 1'b1, 32'h4);
    chk_mem("e3", 1'b1, 32'h8);
    chk("wrap.e3", if2PC, 32'hFFFF_FFFC);
    tick();                                   // E4
    chk_out("e4", 1'b1, 32'h8);
    chk_mem("e4", 1'b1, 32'hC);
    chk("wrap.e4.pc", if2PC, 32'h0);
    chk("wrap.e4.inst", if2Inst, 32'hFFFF_FFFF);

    // Three-cycle stall while presenting 8.
    stall = 1'b1;
    tick();                                   // E5: 12 into skid
    chk_out("e5", 1'b1, 32'h8);
    chk("e5.req", {31'd0, memReq}, 32'd0);
    chk("e5.state", {30'd0, dbgState}, {30'd0, S_HOLD});
    chk("e5.skValid", {31'd0, dut.skValid}, 32'd1);
    chk("e5.skPC", dut.skPC, 32'hC);
    tick();                                   // E6
    chk_out("e6", 1'b1, 32'h8);
    chk("e6.req", {31'd0, memReq}, 32'd0);
    tick();                                   // E7
    chk_out("e7", 1'b1, 32'h8);
    chk("e7.skPC", dut.skPC, 32'hC);
    stall = 1'b0;
    tick();                                   // E8: skid drains
    chk_out("e8", 1'b1, 32'hC);
    chk_mem("e8", 1'b1, 32'h10);
    chk("e8.skValid", {31'd0, dut.skValid}, 32'd0);
    tick();                                   // E9
    chk_out("e9", 1'b1, 32'h10);
    tick();                                   // E10
    chk_out("e10", 1'b1, 32'h14);
    chk_mem("e10", 1'b1, 32'h18);

    // Latency memory: redirect to 0x10 with request to 0x18 outstanding.
    zeroWait = 1'b0; manAck = 1'b0;
    branchFlag = 1'b1; branchTarget = 32'h10;
    tick();                                   // E11
    branchFlag = 1'b0;
    chk("e11.state", {30'd0, dbgState}, {30'd0, S_DROP});
    chk_mem("e11", 1'b1, 32'h18);
    chk_out("e11", 1'b0, 32'h0);
    manAck = 1'b1;
    tick();                                   // E12: discarded ack
    manAck = 1'b0;
    chk("e12.state", {30'd0, dbgState}, {30'd0, S_FETCH});
    chk_mem("e12", 1'b1, 32'h10);
    chk_out("e12", 1'b0, 32'h0);
    tick();                                   // E13: still waiting
    chk_mem("e13", 1'b1, 32'h10);
    branchFlag = 1'b1; branchTarget = 32'h100;
    tick();                                   // E14: redirect, 0x10 outstanding
    branchFlag = 1'b0;
    chk("e14.state", {30'd0, dbgState}, {30'd0, S_DROP});
    chk_mem("e14", 1'b1, 32'h10);
    tick();                                   // E15
    chk_mem("e15", 1'b1, 32'h10);
    chk_out("e15", 1'b0, 32'h0);
    manAck = 1'b1;
    tick();                                   // E16: 0x10 data discarded
    chk_mem("e16", 1'b1, 32'h100);
    chk_out("e16", 1'b0, 32'h0);
    tick();                                   // E17: fetch 0x100
    chk_out("e17", 1'b1, 32'h100);
    chk_mem("e17", 1'b1, 32'h104);

    // Redirect in the same cycle as an ack; low target bits forced to 00.
    zeroWait = 1'b1; manAck = 1'b0;
    branchFlag = 1'b1; branchTarget = 32'h203;
    tick();                                   // E18
    branchFlag = 1'b0;
    chk("e18.state", {30'd0, dbgState}, {30'd0, S_FETCH});
    chk_mem("e18", 1'b1, 32'h200);
    chk_out("e18", 1'b0, 32'h0);
    tick();                                   // E19
    chk_out("e19", 1'b1, 32'h200);

    // Async reset while in DROP, with a stale ack during reset.
    zeroWait = 1'b0; manAck = 1'b0;
    branchFlag = 1'b1; branchTarget = 32'h40;
    tick();                                   // E20
    branchFlag = 1'b0;
    chk("e20.state", {30'd0, dbgState}, {30'd0, S_DROP});
    #2 rst = 1'b1;
    #1;
    chk("arst.state", {30'd0, dbgState}, {30'd0, S_IDLE});
    chk_out("arst", 1'b0, 32'h0);
    chk_mem("arst", 1'b0, 32'h0);
    manAck = 1'b1;
    tick(); tick();
    chk("arst2.state", {30'd0, dbgState}, {30'd0, S_IDLE});
    chk_out("arst2", 1'b0, 32'h0);
    manAck = 1'b0;
    rst = 1'b0;
    tick();                                   // restart: IDLE -> FETCH
    chk("rs1.state", {30'd0, dbgState}, {30'd0, S_FETCH});
    chk_mem("rs1", 1'b1, 32'h0);
    chk_out("rs1", 1'b0, 32'h0);
    zeroWait = 1'b1;
    tick();
    chk_out("rs2", 1'b1, 32'h0);
    chk_mem("rs2", 1'b1, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
